// File: rtl/jtag_scan_pkg.sv
// Shared types and TMS sequences for the JTAG scan engine.
package jtag_scan_pkg;

  typedef enum logic [2:0] {
    ST_RESET_SEQ,
    ST_IDLE,
    ST_PRE,
    ST_SHIFT,
    ST_POST,
    ST_RESP
  } state_e;

  // TMS sequences are applied LSB first, starting from Run-Test/Idle
  localparam logic [3:0] DR_PRE_TMS = 4'b0001;
  localparam int         DR_PRE_LEN = 3;
  localparam logic [3:0] IR_PRE_TMS = 4'b0011;
  localparam int         IR_PRE_LEN = 4;
  localparam logic [1:0] POST_TMS   = 2'b01;
  localparam int         POST_LEN   = 2;

  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: ClkDiv clocks low then ClkDiv clocks high while enabled.
module jtag_tck_gen #(
  parameter int ClkDiv = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int            CW       = $clog2(ClkDiv) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ClkDiv - 1);

  logic [CW-1:0] cnt;
  logic          wrap;

  // Strobes mark the clk_i cycle whose closing edge toggles TCK
  assign wrap   = en_i && (cnt == CNT_LAST);
  assign rise_o = wrap && !tck_o;
  assign fall_o = wrap && tck_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt   <= '0;
      tck_o <= 1'b0;
    end else if (!en_i) begin
      cnt   <= '0;
      tck_o <= 1'b0;
    end else if (wrap) begin
      cnt   <= '0;
      tck_o <= ~tck_o;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/jtag_scan_master.sv
// JTAG scan engine: TAP reset sequence plus IR/DR scans behind valid/ready.
import jtag_scan_pkg::*;

module jtag_scan_master #(
  parameter  int MaxLen    = 64,
  parameter  int ClkDiv    = 4,
  parameter  int TlrCycles = 5,
  localparam int LW        = len_width(MaxLen)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_is_ir_i,
  input  logic [LW-1:0]     req_len_i,
  input  logic [MaxLen-1:0] req_data_i,
  input  logic              tap_reset_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [MaxLen-1:0] rsp_data_o,
  output logic              rsp_err_o,
  output logic              busy_o,
  output logic              jtag_tck_o,
  output logic              jtag_tms_o,
  output logic              jtag_tdi_o,
  input  logic              jtag_tdo_i,
  output logic              jtag_trst_no
);

  localparam int            SW       = $clog2(TlrCycles + 1);
  localparam logic [SW-1:0] TLR_LAST = SW'(TlrCycles);

  state_e              state, state_nx;
  logic                tck_en, rise, fall, legal;
  logic                is_ir_q, err_q, trst_q, tms_q, tdi_q;
  logic [LW-1:0]       len_q, bit_cnt;
  logic [SW-1:0]       seq_cnt, pre_last;
  logic [3:0]          tms_seq;
  logic [MaxLen-1:0]   data_q, cap_q;

  jtag_tck_gen #(.ClkDiv(ClkDiv)) u_tck (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (tck_en),
    .tck_o  (jtag_tck_o),
    .rise_o (rise),
    .fall_o (fall)
  );

  assign legal    = (req_len_i != '0) && (req_len_i <= LW'(MaxLen));
  assign pre_last = is_ir_q ? SW'(IR_PRE_LEN - 1) : SW'(DR_PRE_LEN - 1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_RESET_SEQ;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    tck_en      = 1'b0;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    busy_o      = 1'b1;
    case (state)
      ST_RESET_SEQ: begin
        // TCK holds off for the clk_i cycle that releases TRST
        tck_en = trst_q;
        if (fall && seq_cnt == TLR_LAST) state_nx = ST_IDLE;
      end
      ST_IDLE: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (req_valid_i)      state_nx = legal ? ST_PRE : ST_RESP;
        else if (tap_reset_i) state_nx = ST_RESET_SEQ;
      end
      ST_PRE: begin
        tck_en = 1'b1;
        if (fall && seq_cnt == pre_last) state_nx = ST_SHIFT;
      end
      ST_SHIFT: begin
        tck_en = 1'b1;
        if (fall && bit_cnt == len_q - 1'b1) state_nx = ST_POST;
      end
      ST_POST: begin
        tck_en = 1'b1;
        if (fall && seq_cnt == SW'(POST_LEN - 1)) state_nx = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_nx = ST_IDLE;
      end
      default: state_nx = ST_RESET_SEQ;
    endcase
  end

  // TMS/TDI only move on fall strobes or when a TCK-low phase begins
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      trst_q  <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      seq_cnt <= '0;
      bit_cnt <= '0;
      tms_seq <= '0;
      is_ir_q <= 1'b0;
      len_q   <= '0;
      data_q  <= '0;
      cap_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      trst_q <= 1'b1;
      case (state)
        ST_RESET_SEQ: begin
          if (fall && seq_cnt != TLR_LAST) begin
            seq_cnt <= seq_cnt + 1'b1;
            if (seq_cnt == TLR_LAST - 1'b1) tms_q <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (req_valid_i) begin
            is_ir_q <= req_is_ir_i;
            len_q   <= req_len_i;
            data_q  <= req_data_i;
            cap_q   <= '0;
            err_q   <= !legal;
            seq_cnt <= '0;
            bit_cnt <= '0;
            tdi_q   <= 1'b0;
            if (legal) begin
              tms_q   <= req_is_ir_i ? IR_PRE_TMS[0] : DR_PRE_TMS[0];
              tms_seq <= (req_is_ir_i ? IR_PRE_TMS : DR_PRE_TMS) >> 1;
            end
          end else if (tap_reset_i) begin
            tms_q   <= 1'b1;
            seq_cnt <= '0;
          end
        end
        ST_PRE: begin
          if (fall) begin
            if (seq_cnt == pre_last) begin
              tms_q  <= (len_q == LW'(1));
              tdi_q  <= data_q[0];
              data_q <= data_q >> 1;
            end else begin
              seq_cnt <= seq_cnt + 1'b1;
              tms_q   <= tms_seq[0];
              tms_seq <= tms_seq >> 1;
            end
          end
        end
        ST_SHIFT: begin
          if (rise) cap_q <= cap_q | (MaxLen'(jtag_tdo_i) << bit_cnt);
          if (fall) begin
            if (bit_cnt == len_q - 1'b1) begin
              tms_q   <= POST_TMS[0];
              tdi_q   <= 1'b0;
              seq_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tms_q   <= (bit_cnt + LW'(2) == len_q);
              tdi_q   <= data_q[0];
              data_q  <= data_q >> 1;
            end
          end
        end
        ST_POST: begin
          if (fall) begin
            seq_cnt <= seq_cnt + 1'b1;
            tms_q   <= POST_TMS[1];
          end
        end
        default: ;
      endcase
    end
  end

  assign jtag_tms_o   = tms_q;
  assign jtag_tdi_o   = tdi_q;
  assign jtag_trst_no = trst_q;
  assign rsp_data_o   = cap_q;
  assign rsp_err_o    = err_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Directed bench: jtag_scan_master against a behavioural TAP with IDCODE/BYPASS.
module tb_jtag_scan_master;

  localparam int CD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_is_ir = 1'b0, tap_reset = 1'b0, rsp_ready = 1'b0;
  logic [6:0]  req_len = '0;
  logic [63:0] req_data = '0;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [63:0] rsp_data;
  logic        tck, tms, tdi, trst_n;
  logic        tdo = 1'b0;

  logic        r2_ready, r2_valid, r2_err, r2_busy, r2_tck, r2_tms, r2_tdi, r2_trst_n;
  logic [63:0] r2_data;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  jtag_scan_master #(.MaxLen(64), .ClkDiv(CD), .TlrCycles(5)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_is_ir_i(req_is_ir), .req_len_i(req_len), .req_data_i(req_data),
    .tap_reset_i(tap_reset), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_err_o(rsp_err), .busy_o(busy),
    .jtag_tck_o(tck), .jtag_tms_o(tms), .jtag_tdi_o(tdi), .jtag_tdo_i(tdo),
    .jtag_trst_no(trst_n)
  );

  // Second engine with ClkDiv=2, only exercised through reset
  jtag_scan_master #(.MaxLen(64), .ClkDiv(2), .TlrCycles(5)) dut2 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(1'b0), .req_ready_o(r2_ready),
    .req_is_ir_i(1'b0), .req_len_i(7'd0), .req_data_i(64'd0),
    .tap_reset_i(1'b0), .rsp_valid_o(r2_valid), .rsp_ready_i(1'b0),
    .rsp_data_o(r2_data), .rsp_err_o(r2_err), .busy_o(r2_busy),
    .jtag_tck_o(r2_tck), .jtag_tms_o(r2_tms), .jtag_tdi_o(r2_tdi), .jtag_tdo_i(1'b0),
    .jtag_trst_no(r2_trst_n)
  );

  // ---- behavioural TAP: IR 5 bits, IDCODE=0x01, BYPASS=0x1F ----
  typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                            SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_e;
  tap_e        ts;
  logic [4:0]  ir, ir_sh;
  logic [31:0] dr_sh;
  logic        byp;

  always @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      ts <= TLR; ir <= 5'h01; ir_sh <= '0; dr_sh <= '0; byp <= 1'b0;
    end else begin
      case (ts)
        TLR:   ir <= 5'h01;
        CAPDR: begin dr_sh <= 32'h1234_5677; byp <= 1'b0; end
        SHDR:  begin dr_sh <= {tdi, dr_sh[31:1]}; byp <= tdi; end
        CAPIR: ir_sh <= 5'b00001;
        SHIR:  ir_sh <= {tdi, ir_sh[4:1]};
        UPIR:  ir <= ir_sh;
        default: ;
      endcase
      case (ts)
        TLR:   ts <= tms ? TLR   : RTI;
        RTI:   ts <= tms ? SELDR : RTI;
        SELDR: ts <= tms ? SELIR : CAPDR;
        CAPDR: ts <= tms ? EX1DR : SHDR;
        SHDR:  ts <= tms ? EX1DR : SHDR;
        EX1DR: ts <= tms ? UPDR  : PADR;
        PADR:  ts <= tms ? EX2DR : PADR;
        EX2DR: ts <= tms ? UPDR  : SHDR;
        UPDR:  ts <= tms ? SELDR : RTI;
        SELIR: ts <= tms ? TLR   : CAPIR;
        CAPIR: ts <= tms ? EX1IR : SHIR;
        SHIR:  ts <= tms ? EX1IR : SHIR;
        EX1IR: ts <= tms ? UPIR  : PAIR;
        PAIR:  ts <= tms ? EX2IR : PAIR;
        EX2IR: ts <= tms ? UPIR  : SHIR;
        default: ts <= tms ? SELDR : RTI;
      endcase
    end
  end

  always @(negedge tck) begin
    if (ts == SHDR)      tdo <= (ir == 5'h01) ? dr_sh[0] : byp;
    else if (ts == SHIR) tdo <= ir_sh[0];
  end

  // ---- monitors: TMS log per TCK rise, edge-rule watcher ----
  logic tms_log[$];
  int   rise_cnt = 0, edge_viol = 0;
  logic p_tck = 1'b0, p_tms = 1'b0, p_tdi = 1'b0;

  always @(posedge tck) begin
    tms_log.push_back(tms);
    rise_cnt++;
  end

  always @(negedge clk) begin
    if (!rst && p_tck && tck && (tms !== p_tms || tdi !== p_tdi)) edge_viol++;
    p_tck = tck; p_tms = tms; p_tdi = tdi;
  end

  function automatic logic [15:0] pack_log();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < tms_log.size() && i < 16; i++) v[i] = tms_log[i];
    return v;
  endfunction

  // ---- drivers ----
  task automatic scan(input logic ir_scan, input int len, input logic [63:0] d,
                      input logic tr, output logic [63:0] q, output logic e, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_is_ir = ir_scan; req_len = 7'(len); req_data = d; tap_reset = tr;
    n = 0;
    while (req_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0; tap_reset = 1'b0; req_len = '1; req_data = '1;
    lat = 1;  // counted from the start of the accept cycle
    while (rsp_valid !== 1'b1 && lat < 5000) begin @(posedge clk); #1; lat++; end
    q = rsp_data; e = rsp_err;
    checks++;
    if (rsp_valid !== 1'b1 || n >= 2000) begin
      errors++; $display("FAIL scan_timeout: rsp_valid=%b wait=%0d lat=%0d", rsp_valid, n, lat);
    end
  endtask

  task automatic consume();
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 1000) begin @(posedge clk); #1; n++; end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL %s_idle: req_ready=%b required 1", tag, req_ready); end
  endtask

  // ---- tests ----
  task automatic test_reset();
    int f1, f2;
    tms_log.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({tck, tms, tdi, trst_n, req_ready, rsp_valid, rsp_err, busy} !== 8'b0100_0001 || rsp_data !== 64'd0) begin
      errors++; $display("FAIL reset_values: got %b data %h required 01000001 data 0",
        {tck, tms, tdi, trst_n, req_ready, rsp_valid, rsp_err, busy}, rsp_data);
    end
    checks++;
    if ({r2_tck, r2_tms, r2_trst_n, r2_ready, r2_busy} !== 5'b01001) begin
      errors++; $display("FAIL reset_values_div2: got %b required 01001", {r2_tck, r2_tms, r2_trst_n, r2_ready, r2_busy});
    end
    rst = 1'b0;
    f1 = 0; f2 = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        checks++;
        if (trst_n !== 1'b1 || r2_trst_n !== 1'b1 || tck !== 1'b0) begin
          errors++; $display("FAIL trst_release: trst=%b/%b tck=%b required 1/1/0", trst_n, r2_trst_n, tck);
        end
      end
      if (f1 == 0 && tck === 1'b1) f1 = i;
      if (f2 == 0 && r2_tck === 1'b1) f2 = i;
    end
    checks++;
    if (f2 != 3) begin errors++; $display("FAIL first_rise_div2: edge %0d required 3", f2); end
    checks++;
    if (f1 != 1 + CD) begin errors++; $display("FAIL first_rise_div4: edge %0d required %0d", f1, 1 + CD); end
    wait_idle("reset");
    checks++;
    if (tms_log.size() != 6 || pack_log() !== 16'h001F) begin
      errors++; $display("FAIL reset_tms_seq: %0d rises pattern %h required 6 rises 001f", tms_log.size(), pack_log());
    end
  endtask

  task automatic test_idcode();
    logic [63:0] q; logic e; int lat;
    tms_log.delete();
    scan(1'b1, 5, 64'h01, 1'b0, q, e, lat);
    checks++;
    if (q !== 64'h01 || e !== 1'b0) begin errors++; $display("FAIL ir_capture: data %h err %b required 01 err 0", q, e); end
    checks++;
    if (lat != 11 * 2 * CD + 1) begin errors++; $display("FAIL ir_latency: %0d required %0d", lat, 11 * 2 * CD + 1); end
    checks++;
    if (tms_log.size() != 11 || pack_log() !== 16'h0303) begin
      errors++; $display("FAIL ir_tms_seq: %0d rises pattern %h required 11 rises 0303", tms_log.size(), pack_log());
    end
    consume();
    scan(1'b0, 32, 64'h0, 1'b0, q, e, lat);
    checks++;
    if (q !== 64'h1234_5677 || e !== 1'b0) begin errors++; $display("FAIL idcode: data %h err %b required 12345677 err 0", q, e); end
    checks++;
    if (lat != 37 * 2 * CD + 1) begin errors++; $display("FAIL dr_latency: %0d required %0d", lat, 37 * 2 * CD + 1); end
    consume();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rsp_handshake: valid %b ready %b required 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_bypass();
    logic [63:0] q; logic e; int lat;
    scan(1'b1, 5, 64'h1F, 1'b0, q, e, lat);
    consume();
    scan(1'b0, 64, 64'hDEAD_BEEF_0123_4567, 1'b0, q, e, lat);
    checks++;
    if (q !== 64'hBD5B_7DDE_0246_8ACE || e !== 1'b0) begin
      errors++; $display("FAIL bypass64: data %h err %b required bd5b7dde02468ace err 0", q, e);
    end
    checks++;
    if (lat != 69 * 2 * CD + 1) begin errors++; $display("FAIL bypass_latency: %0d required %0d", lat, 69 * 2 * CD + 1); end
    consume();
  endtask

  task automatic test_illegal();
    logic [63:0] q; logic e; int lat, r0;
    int lens[2] = '{0, 65};
    foreach (lens[k]) begin
      r0 = rise_cnt;
      scan(1'b0, lens[k], 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, q, e, lat);
      checks++;
      if (e !== 1'b1 || q !== 64'd0 || lat != 1) begin
        errors++; $display("FAIL illegal_len%0d: err %b data %h lat %0d required 1 0 1", lens[k], e, q, lat);
      end
      consume();
      checks++;
      if (rise_cnt != r0 || tck !== 1'b0) begin
        errors++; $display("FAIL illegal_tck_len%0d: %0d rises tck %b required 0 rises tck 0", lens[k], rise_cnt - r0, tck);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] q; logic e; int lat, bad, r0;
    scan(1'b0, 8, 64'hA5, 1'b0, q, e, lat);
    checks++;
    if (q !== 64'h4A) begin errors++; $display("FAIL bp_data: %h required 4a", q); end
    bad = 0;
    r0 = rise_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_len = 7'd4; req_data = 64'h3;
      if (rsp_valid !== 1'b1 || rsp_data !== q || req_ready !== 1'b0 || rsp_err !== 1'b0) bad++;
    end
    @(negedge clk); req_valid = 1'b0;
    checks++;
    if (bad != 0 || rise_cnt != r0) begin
      errors++; $display("FAIL bp_hold: %0d unstable cycles %0d rises required 0 0", bad, rise_cnt - r0);
    end
    consume();
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_release: valid %b busy %b required 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_tap_reset();
    logic [63:0] q; logic e; int lat, sawv;
    tms_log.delete();
    @(negedge clk); tap_reset = 1'b1;
    @(negedge clk); tap_reset = 1'b0;
    checks++;
    if (busy !== 1'b1 || trst_n !== 1'b1) begin
      errors++; $display("FAIL tap_reset_enter: busy %b trst %b required 1 1", busy, trst_n);
    end
    sawv = 0;
    for (int n = 0; n < 1000 && req_ready !== 1'b1; n++) begin
      @(posedge clk); #1;
      if (rsp_valid === 1'b1 || trst_n !== 1'b1) sawv++;
    end
    checks++;
    if (sawv != 0 || tms_log.size() != 6 || pack_log() !== 16'h001F || ts !== RTI) begin
      errors++; $display("FAIL tap_reset_seq: bad %0d rises %0d pattern %h required 0 6 001f", sawv, tms_log.size(), pack_log());
    end
    tms_log.delete();
    scan(1'b0, 32, 64'h0, 1'b1, q, e, lat);
    checks++;
    if (q !== 64'h1234_5677 || tms_log.size() != 37) begin
      errors++; $display("FAIL reset_with_req: data %h rises %0d required 12345677 37", q, tms_log.size());
    end
    consume();
  endtask

  task automatic test_mid_reset();
    logic [63:0] q; logic e; int lat, r0, n;
    @(negedge clk);
    req_valid = 1'b1; req_is_ir = 1'b0; req_len = 7'd32; req_data = 64'h0;
    @(posedge clk); #1; req_valid = 1'b0;
    r0 = rise_cnt; n = 0;
    while (rise_cnt < r0 + 14 && n < 2000) begin @(posedge clk); #1; n++; end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({tck, tms, trst_n, rsp_valid, busy} !== 5'b01001 || n >= 2000) begin
      errors++; $display("FAIL mid_reset: tck/tms/trst/valid/busy %b required 01001", {tck, tms, trst_n, rsp_valid, busy});
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    tms_log.delete();
    wait_idle("mid_reset");
    checks++;
    if (pack_log() !== 16'h001F || tms_log.size() != 6) begin
      errors++; $display("FAIL mid_reset_tlr: rises %0d pattern %h required 6 001f", tms_log.size(), pack_log());
    end
    scan(1'b0, 32, 64'h0, 1'b0, q, e, lat);
    checks++;
    if (q !== 64'h1234_5677 || e !== 1'b0) begin errors++; $display("FAIL post_reset_idcode: %h required 12345677", q); end
    consume();
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_bypass();
    test_illegal();
    test_backpressure();
    test_tap_reset();
    test_mid_reset();
    checks++;
    if (edge_viol != 0) begin errors++; $display("FAIL edge_rule: %0d tms/tdi changes with tck high required 0", edge_viol); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_scan_master.md
Name: jtag_scan_master

Overview:
- Synthesizable JTAG scan engine that drives a standard 4-wire TAP plus TRST from a single system clock.
- Executes IR or DR scans of programmable length with a valid/ready request/response handshake, and returns the captured TDO bits.
- Parametrised in maximum scan length, TCK divider and TAP-reset sequence.
- Used as an on-chip or FPGA-side debug master in front of the debug module TAP, and as a reusable bench driver for system-level JTAG tests (idcode, dtmcs, memory programming).

Parameters:
- MaxLen, 64: maximum scan length in bits; sets the width of the data ports.
- ClkDiv, 4: clk_i cycles per TCK half-period; must be ≥1.
- TlrCycles, 5: TCK cycles with TMS=1 in the TAP-reset sequence; must be ≥5.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- req_valid_i  in  1  scan request valid
- req_ready_o  out  1  engine can accept a request
- req_is_ir_i  in  1  1 = IR scan, 0 = DR scan
- req_len_i  in  $clog2(MaxLen+1)  number of bits to shift
- req_data_i  in  MaxLen  TDI bits, LSB shifted first
- tap_reset_i  in  1  request TLR sequence (sampled only when idle)
- rsp_valid_o  out  1  scan result valid
- rsp_ready_i  in  1  result consumed
- rsp_data_o  out  MaxLen  captured TDO bits, LSB first; bits ≥len are zero
- rsp_err_o  out  1  request rejected (illegal length)
- busy_o  out  1  engine not in IDLE
- jtag_tck_o  out  1  TCK
- jtag_tms_o  out  1  TMS
- jtag_tdi_o  out  1  TDI
- jtag_tdo_i  in  1  TDO
- jtag_trst_no  out  1  TAP reset, active low

Behaviour:
- Reset values:
  - tck=0, tms=1, tdi=0, trst_no=0.
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=1.
- TCK generation:
  - Idles low.
  - Each TCK cycle is ClkDiv clk_i low, then ClkDiv clk_i high (2*ClkDiv clk_i per cycle).
- Edge rules:
  - TMS/TDI change only at TCK falling-edge time, or at cycle start while TCK is low.
  - TDO is sampled in the clk_i cycle of the TCK rising edge.
- FSM states and transitions:
  - RESET_SEQ: after rst_i release, trst_no=1 on the first clk_i, then TlrCycles TCK with TMS=1, then 1 TCK with TMS=0 (TAP now in Run-Test/Idle), then go to IDLE.
  - IDLE: req_ready=1 only if rsp_valid=0.
    - tap_reset_i=1 with req_valid_i=0 → RESET_SEQ; trst_no stays 1; no response is produced.
    - tap_reset_i=1 with req_valid_i=1 in the same cycle: the request is accepted and the reset is ignored.
  - PRE: TMS sequence 1,0,0 for DR (Select-DR, Capture-DR, Shift-DR) or 1,1,0,0 for IR. TDI=0 throughout.
  - SHIFT: len TCK cycles; TDI = req_data[i]; TMS=1 on bit len-1 only (to Exit1). The TDO sampled at rising edge i goes to rsp_data[i].
  - POST: TMS 1,0 (Update → Run-Test/Idle).
  - RESP: rsp_valid=1; held with stable data until rsp_ready_i=1; then go to IDLE.
- Handshakes:
  - A request is accepted on a cycle with req_valid_i & req_ready_o. Request fields are registered at accept; inputs are don't-care afterwards.
  - Response transfers on rsp_valid & rsp_ready.
- Latency: accept → rsp_valid = (len+5)*2*ClkDiv + 1 clk_i for DR, and (len+6)*2*ClkDiv + 1 clk_i for IR.
- Illegal length:
  - len=0 or len>MaxLen → no TCK activity.
  - rsp_valid with rsp_err=1 and rsp_data=0 the cycle after accept.
- Reset mid-scan: all outputs return to reset values asynchronously; the pending response is lost; RESET_SEQ reruns after release.
- Counters: bit counter width $clog2(MaxLen+1); divider counter width $clog2(ClkDiv)+1; no wrap within a scan.

Decomposition:
- Shared package jtag_scan_pkg:
  - FSM state enum (RESET_SEQ, IDLE, PRE, SHIFT, POST, RESP).
  - DR/IR preamble TMS constants and their lengths.
  - Length-width function.
- Sub-module jtag_tck_gen:
  - Divider producing tck plus one-cycle strobes rise_o and fall_o.
  - Enable input; idles with TCK low.

Test Plan:
- Reset sequence: rst_i for 3 cycles, ClkDiv=2 → trst_no low during reset; then 5 TCK with TMS=1 and 1 with TMS=0; first TCK rising edge 1+2 clk_i after release; req_ready=1 afterwards.
- IDCODE: IR scan len=5 data=0x01, then DR scan len=32 against a bench TAP model returning 0x1234_5677 → rsp_data=0x1234_5677; IR response = 0x01 capture pattern (0b00001); DR latency = 37*8+1 clk_i.
- Bypass loop: DR len=64 data=0xDEAD_BEEF_0123_4567 through a 1-bit bypass → rsp_data = data<<1 with bit0=0; rsp_err=0.
- Illegal length: len=0 and len=65 → rsp_err=1 and rsp_data=0 one cycle after accept; TCK stays low.
- Backpressure: rsp_ready_i=0 for 20 cycles after a scan → rsp_valid/rsp_data stable; req_ready=0; a new request is not accepted until the handshake completes.
- Mid-scan reset: rst_i asserted during SHIFT bit 10 → tck=0, tms=1, trst_no=0 immediately; TLR sequence reruns; the next scan returns correct data.
